fetch_prefetch_queue: RTL and testbench
=======================================

# fetch_prefetch_queue

Instruction prefetch buffer between the instruction memory read port and the decode stage. It walks a word-aligned fetch PC and issues one read per cycle while buffer space exists. It captures the 1-cycle-latency read data together with its PC in a FIFO, and presents instructions to decode with a valid/ready handshake. A taken branch from execute flushes the queue, discards any in-flight read and redirects fetch to the branch target.

## Interface

Parameters:
- DEPTH, 4, FIFO entries; legal range 2..16; full throughput requires DEPTH ≥ 3.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous assertion, active-low (0 = in reset).
- mem_req  out  1  read request to instruction memory this cycle.
- mem_addr  out  32  byte address of the read; always word-aligned.
- mem_rdata  in  32  read data; valid exactly one cycle after the cycle with mem_req=1.
- branch_taken  in  1  flush and redirect request from execute.
- branch_target  in  32  redirect address; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  an instruction is presented to decode.
- out_ready  in  1  decode accepts; a transfer occurs when out_valid & out_ready.
- out_pc  out  32  PC of the presented instruction.
- out_instr  out  32  presented instruction word.

## Operation

- State:
  - fetch_pc (32b): next address to request.
  - count: FIFO occupancy, 0..DEPTH.
  - inflight (1b): a request was issued last cycle and its data arrives this cycle.
  - inflight_pc (32b).
  - FIFO storage of {pc, instr}, with read and write pointers modulo DEPTH.
- Reset values while rst=0:
  - fetch_pc=RESET_PC; count=0; inflight=0; pointers=0.
  - mem_req=0, mem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0.
- Request rule (combinational):
  - mem_req = rst & !branch_taken & (count + inflight < DEPTH).
  - Pops in the current cycle are not credited.
  - mem_addr = fetch_pc.
- On a cycle with mem_req=1:
  - fetch_pc ← fetch_pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
  - inflight ← 1; inflight_pc ← fetch_pc.
  - Otherwise inflight ← 0.
- Capture: if inflight=1 and branch_taken=0, write {inflight_pc, mem_rdata} at the write pointer. The request rule guarantees no overflow.
- Output:
  - out_valid = (count ≠ 0).
  - out_pc/out_instr = entry at the read pointer; they hold stable while out_valid & !out_ready.
  - A pop advances the read pointer.
  - Simultaneous push and pop leaves count unchanged.
- Flush (branch_taken=1, sampled on the clock edge):
  - count ← 0; pointers ← 0; inflight ← 0; fetch_pc ← {branch_target[31:2], 2'b00}.
  - Any data arriving this cycle is discarded.
  - A pop in the same cycle is ignored; decode must not treat it as consumed.
  - mem_req=0 in the flush cycle.
  - Back-to-back flushes: the last one wins.
- Out-of-range FIFO states are unreachable. Count width is $clog2(DEPTH+1).

## Timing

- Latency:
  - Request in cycle N → data captured at the end of N+1 → out_valid=1 in N+2 (2 cycles; no bypass).
- After reset release (first clk edge with rst=1, cycle 0):
  - mem_req=1, addr RESET_PC in cycle 0.
  - First out_valid in cycle 2.
- Flush:
  - Flush in cycle F → out_valid=0 in F+1.
  - mem_req=1 with the target address in F+1.
  - Target instruction has out_valid=1 in F+3.
- Throughput: with out_ready held at 1 and DEPTH ≥ 3, one instruction per cycle sustained with consecutive PCs.
- Backpressure:
  - With out_ready=0, requests stop once count + inflight = DEPTH.
  - No data is lost or duplicated.
  - Fetch resumes the cycle after count + inflight drops below DEPTH.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronous).
  - Outputs go to their reset values in the same cycle.
  - In-flight data is dropped.

## Test plan

- Reset release, RESET_PC=0, out_ready=1, memory returns addr^32'hA5A5_0000 → out_valid from cycle 2, out_pc = 0, 4, 8, … one per cycle, with matching instr.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests (addr 0, 4, 8, C), count=4, mem_req=0. Release out_ready → pops 0, 4, 8, C in order, then fetch resumes at 0x10.
- branch_taken with target 0x100 while count=3 and inflight=1 → next cycle out_valid=0, mem_addr=0x100. First output out_pc=0x100 three cycles after the flush. No stale PC is ever presented.
- branch_target=0x203 → fetch redirects to 0x200. Flush coincident with out_valid & out_ready → popped entry is not re-presented and is not counted.
- fetch_pc starting at 0xFFFF_FFF8 via a flush → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst driven low asynchronously mid-stream (between edges) → out_valid=0 and mem_req=0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: walks a word-aligned fetch PC, captures 1-cycle-latency read
// data with its PC in a small FIFO and hands instructions to decode; branches flush and redirect.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [CW:0]   occupancy;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Outstanding read reserves a slot so its data can never overflow the FIFO.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign mem_req   = rst & ~branch_taken & (occupancy < DEPTH_W);
  assign mem_addr  = fetch_pc_q;

  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;

  assign push = inflight_q & ~branch_taken;
  assign pop  = out_valid & out_ready & ~branch_taken;

  always_comb begin
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = mem_req;
    if (branch_taken) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = branch_target & 32'hFFFF_FFFC;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (mem_req) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  // Storage needs no reset: entries are only visible once count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
      instr_mem[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: queue-based reference model checked every cycle,
// plus hand-computed expectations for reset, backpressure, flush, wrap and async reset.
module tb_fetch_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference model: next fetch address, one outstanding read, queue of buffered PCs.
  logic [31:0] m_fpc;
  logic [31:0] m_ipc;
  logic        m_infl;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  fetch_prefetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr)
  );

  // Instruction memory: data one cycle after the request, garbage when nothing was asked.
  always @(posedge clk) mem_rdata <= mem_req ? (mem_addr ^ KEY) : ~mem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fpc  = RESET_PC;
    m_ipc  = '0;
    m_infl = 1'b0;
    m_q.delete();
  endtask

  task automatic model_update();
    bit req;
    req = rst && !branch_taken && (m_q.size() + int'(m_infl) < int'(DEPTH));
    if (!rst) begin
      model_reset();
    end else if (branch_taken) begin
      m_q.delete();
      m_infl = 1'b0;
      m_fpc  = {branch_target[31:2], 2'b00};
    end else begin
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_ipc);
      if (req) begin
        m_ipc  = m_fpc;
        m_fpc  = m_fpc + 32'd4;
        m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin : compare
    logic        exp_req;
    logic        exp_v;
    logic [31:0] exp_pc;
    if (chk_en) begin
      exp_req = rst && !branch_taken && (m_q.size() + int'(m_infl) < int'(DEPTH));
      exp_v   = rst && (m_q.size() != 0);
      exp_pc  = exp_v ? m_q[0] : 32'h0;
      check("cyc_mem_req", 32'(mem_req), 32'(exp_req));
      check("cyc_mem_addr", mem_addr, m_fpc);
      check("cyc_out_valid", 32'(out_valid), 32'(exp_v));
      check("cyc_out_pc", out_pc, exp_pc);
      check("cyc_out_instr", out_instr, exp_v ? (exp_pc ^ KEY) : 32'h0);
    end
  end

  task automatic cyc(input logic br, input logic [31:0] tgt, input logic rdy);
    @(posedge clk);
    model_update();
    #1;
    branch_taken  = br;
    branch_target = tgt;
    out_ready     = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic release_rst(input logic rdy);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    out_ready     = rdy;
    @(negedge clk);
    #1;
  endtask

  // Drop reset between edges and confirm outputs react without waiting for a clock.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_mem_req", 32'(mem_req), 32'h0);
    check("arst_mem_addr", mem_addr, RESET_PC);
    check("arst_out_pc", out_pc, 32'h0);
  endtask

  initial begin
    logic [31:0] req_addrs[$];
    logic [31:0] exp_addrs[4];
    exp_addrs[0] = 32'h0;
    exp_addrs[1] = 32'h4;
    exp_addrs[2] = 32'h8;
    exp_addrs[3] = 32'hC;

    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Reset release and streaming with out_ready=1.
    release_rst(1'b1);
    check("rel_mem_req", 32'(mem_req), 32'h1);
    check("rel_mem_addr", mem_addr, 32'h0);
    check("rel_out_valid", 32'(out_valid), 32'h0);
    cyc(1'b0, '0, 1'b1);
    check("c1_mem_addr", mem_addr, 32'h4);
    check("c1_out_valid", 32'(out_valid), 32'h0);
    cyc(1'b0, '0, 1'b1);
    check("c2_out_valid", 32'(out_valid), 32'h1);
    check("c2_out_pc", out_pc, 32'h0);
    check("c2_out_instr", out_instr, 32'hA5A5_0000);
    cyc(1'b0, '0, 1'b1);
    check("c3_out_pc", out_pc, 32'h4);
    check("c3_out_instr", out_instr, 32'hA5A5_0004);
    cyc(1'b0, '0, 1'b1);
    check("c4_out_pc", out_pc, 32'h8);

    // Backpressure: exactly DEPTH requests then stall.
    async_reset();
    release_rst(1'b0);
    if (mem_req) req_addrs.push_back(mem_addr);
    repeat (9) begin
      cyc(1'b0, '0, 1'b0);
      if (mem_req) req_addrs.push_back(mem_addr);
    end
    check("bp_req_count", 32'(req_addrs.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_addrs.size(); i++) check("bp_req_addr", req_addrs[i], exp_addrs[i]);
    check("bp_full_valid", 32'(out_valid), 32'h1);
    check("bp_full_req", 32'(mem_req), 32'h0);
    cyc(1'b0, '0, 1'b1);
    check("bp_pop0_pc", out_pc, 32'h0);
    check("bp_pop0_req", 32'(mem_req), 32'h0);
    cyc(1'b0, '0, 1'b1);
    check("bp_pop1_pc", out_pc, 32'h4);
    check("bp_resume_req", 32'(mem_req), 32'h1);
    check("bp_resume_addr", mem_addr, 32'h10);
    cyc(1'b0, '0, 1'b1);
    check("bp_pop2_pc", out_pc, 32'h8);
    cyc(1'b0, '0, 1'b1);
    check("bp_pop3_pc", out_pc, 32'hC);
    cyc(1'b0, '0, 1'b1);
    check("bp_pop4_pc", out_pc, 32'h10);

    // Flush with count=3 and a read in flight.
    async_reset();
    release_rst(1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 32'h100, 1'b0);
    check("fl_cycle_req", 32'(mem_req), 32'h0);
    check("fl_cycle_valid", 32'(out_valid), 32'h1);
    cyc(1'b0, '0, 1'b1);
    check("fl1_valid", 32'(out_valid), 32'h0);
    check("fl1_req", 32'(mem_req), 32'h1);
    check("fl1_addr", mem_addr, 32'h100);
    cyc(1'b0, '0, 1'b1);
    check("fl2_valid", 32'(out_valid), 32'h0);
    check("fl2_addr", mem_addr, 32'h104);
    cyc(1'b0, '0, 1'b1);
    check("fl3_valid", 32'(out_valid), 32'h1);
    check("fl3_pc", out_pc, 32'h100);
    check("fl3_instr", out_instr, 32'hA5A5_0100);
    cyc(1'b0, '0, 1'b1);
    check("fl4_pc", out_pc, 32'h104);

    // Misaligned target, flush coincident with a handshake.
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("ma_pre_valid", 32'(out_valid), 32'h1);
    cyc(1'b1, 32'h203, 1'b1);
    check("ma_cycle_req", 32'(mem_req), 32'h0);
    cyc(1'b0, '0, 1'b1);
    check("ma1_valid", 32'(out_valid), 32'h0);
    check("ma1_addr", mem_addr, 32'h200);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("ma3_pc", out_pc, 32'h200);
    check("ma3_instr", out_instr, 32'hA5A5_0200);

    // Address wrap at the top of the address space.
    cyc(1'b1, 32'hFFFF_FFF8, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("wr1_addr", mem_addr, 32'hFFFF_FFF8);
    cyc(1'b0, '0, 1'b1);
    check("wr2_addr", mem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, '0, 1'b1);
    check("wr3_addr", mem_addr, 32'h0);
    check("wr3_pc", out_pc, 32'hFFFF_FFF8);
    check("wr3_instr", out_instr, 32'h5A5A_FFF8);
    cyc(1'b0, '0, 1'b1);
    check("wr4_pc", out_pc, 32'hFFFF_FFFC);
    cyc(1'b0, '0, 1'b1);
    check("wr5_pc", out_pc, 32'h0);
    check("wr5_instr", out_instr, 32'hA5A5_0000);

    // Asynchronous reset mid-stream, then restart from RESET_PC.
    async_reset();
    release_rst(1'b1);
    check("rs_req", 32'(mem_req), 32'h1);
    check("rs_addr", mem_addr, RESET_PC);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("rs_pc", out_pc, RESET_PC);
    check("rs_instr", out_instr, RESET_PC ^ KEY);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
